// File: rtl/npc_ras_unit_pkg.sv
// Shared control encodings for the next-PC / return-address-stack unit.
// Holds the npc_op and branch-compare encodings plus the branch offset helper.
package npc_ras_unit_pkg;

    localparam int NPCOp_WIDTH    = 3;
    localparam int BrCmp_Op_WIDTH = 3;

    typedef enum logic [NPCOp_WIDTH-1:0] {
        NPC_PLUS4  = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_JR     = 3'd3,
        NPC_JAL    = 3'd4,
        NPC_RET    = 3'd5
    } npc_op_e;

    typedef enum logic [BrCmp_Op_WIDTH-1:0] {
        BEQ_CMP  = 3'd0,
        BNE_CMP  = 3'd1,
        BLEZ_CMP = 3'd2,
        BGTZ_CMP = 3'd3,
        BLTZ_CMP = 3'd4,
        BGEZ_CMP = 3'd5
    } brcmp_op_e;

    // Word offset of a branch: sign-extended imm16 shifted left by two.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_ras_unit_ras_stack.sv
// Circular return-address stack: push writes the next slot, pop drops the top.
// Ports: clk, rst, push, pop, din, top (0 when empty), empty, full, underflow.
module ras_stack
    import npc_ras_unit_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] top_idx;

    // ptr_q is the next free slot; the top lives one below it.
    assign top_idx   = ptr_q - PW'(1);
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign top       = empty ? '0 : mem_q[top_idx];
    assign underflow = pop & empty;

    // Pushing when full overwrites the oldest entry, which is the
    // slot ptr_q has wrapped onto; the count saturates.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (push) begin
                mem_q[ptr_q] <= din;
            end
        end
    end

endmodule

// File: rtl/npc_ras_unit.sv
// Next-PC generator: fetch PC register, branch comparator, jump targets and RAS.
// Ports: clk, rst, stall, npc_op, brcmp_op, id_pc, imm26, rs, rt in; pc, npc,
// laddr, comp, ras_top, ras_empty, ras_full, ras_miss out.
module npc_ras_unit
    import npc_ras_unit_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          RAS_DEPTH = 4,
    parameter bit          EN_RAS    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic [NPCOp_WIDTH-1:0]    npc_op,
    input  logic [BrCmp_Op_WIDTH-1:0] brcmp_op,
    input  logic [ADDR_W-1:0]         id_pc,
    input  logic [25:0]               imm26,
    input  logic [31:0]               rs,
    input  logic [31:0]               rt,
    output logic [ADDR_W-1:0]         pc,
    output logic [ADDR_W-1:0]         npc,
    output logic [ADDR_W-1:0]         laddr,
    output logic                      comp,
    output logic [ADDR_W-1:0]         ras_top,
    output logic                      ras_empty,
    output logic                      ras_full,
    output logic                      ras_miss
);

    localparam logic [ADDR_W-1:0] PC_RST  = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'(32'h0FFF_FFFF);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] plus4, br_tgt, jmp_tgt, reg_tgt;
    logic              rs_zero, rs_neg;
    logic              is_jal, is_ret;
    logic              ras_push, ras_pop;

    assign plus4   = pc_q + ADDR_W'(4);
    assign br_tgt  = id_pc + ADDR_W'(br_offset(imm26[15:0]));
    // Region bits above 28 come from id_pc; the rest from imm26.
    assign jmp_tgt = (id_pc & ~LO_MASK) | ADDR_W'({imm26, 2'b00});
    assign reg_tgt = {rs[ADDR_W-1:2], 2'b00};
    assign laddr   = id_pc + ADDR_W'(8);

    assign rs_zero = (rs == '0);
    assign rs_neg  = rs[31];

    always_comb begin
        comp = 1'b0;
        case (brcmp_op_e'(brcmp_op))
            BEQ_CMP:  comp = (rs == rt);
            BNE_CMP:  comp = (rs != rt);
            BLEZ_CMP: comp = rs_neg | rs_zero;
            BGTZ_CMP: comp = ~rs_neg & ~rs_zero;
            BLTZ_CMP: comp = rs_neg;
            BGEZ_CMP: comp = ~rs_neg;
            default:  comp = 1'b0;
        endcase
    end

    always_comb begin
        npc = plus4;
        case (npc_op_e'(npc_op))
            NPC_PLUS4:  npc = plus4;
            NPC_BRANCH: npc = comp ? br_tgt : plus4;
            NPC_JUMP:   npc = jmp_tgt;
            NPC_JAL:    npc = jmp_tgt;
            NPC_JR:     npc = reg_tgt;
            NPC_RET:    npc = reg_tgt;
            default:    npc = plus4;
        endcase
    end

    assign pc_d = stall ? pc_q : npc;
    assign pc   = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= PC_RST;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign is_jal   = (npc_op == NPCOp_WIDTH'(NPC_JAL));
    assign is_ret   = (npc_op == NPCOp_WIDTH'(NPC_RET));
    assign ras_push = ~stall & is_jal;
    assign ras_pop  = ~stall & is_ret;

    generate
        if (EN_RAS) begin : g_ras
            logic ras_under;
            logic ras_miss_q, ras_miss_d;

            ras_stack #(
                .W     (ADDR_W),
                .DEPTH (RAS_DEPTH)
            ) u_ras (
                .clk       (clk),
                .rst       (rst),
                .push      (ras_push),
                .pop       (ras_pop),
                .din       (laddr),
                .top       (ras_top),
                .empty     (ras_empty),
                .full      (ras_full),
                .underflow (ras_under)
            );

            // Diagnostic only: the architectural target is always rs.
            assign ras_miss_d = ras_pop &
                (ras_under | (ras_top != rs[ADDR_W-1:0]));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ras_miss_q <= 1'b0;
                end else if (!stall) begin
                    ras_miss_q <= ras_miss_d;
                end
            end

            assign ras_miss = ras_miss_q;
        end else begin : g_no_ras
            assign ras_top   = '0;
            assign ras_empty = 1'b1;
            assign ras_full  = 1'b0;
            assign ras_miss  = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_npc_ras_unit.sv
// Directed testbench for npc_ras_unit with default parameters.
// Each task drives one scenario and checks its own hand-computed results.
module tb_npc_ras_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  npc_op;
    logic [2:0]  brcmp_op;
    logic [31:0] id_pc;
    logic [25:0] imm26;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] laddr;
    logic        comp;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_miss;

    int errors = 0;
    int checks = 0;

    npc_ras_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .npc_op    (npc_op),
        .brcmp_op  (brcmp_op),
        .id_pc     (id_pc),
        .imm26     (imm26),
        .rs        (rs),
        .rt        (rt),
        .pc        (pc),
        .npc       (npc),
        .laddr     (laddr),
        .comp      (comp),
        .ras_top   (ras_top),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_miss  (ras_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; npc_op = 3'd0; brcmp_op = 3'd0;
        id_pc = '0; imm26 = '0; rs = '0; rt = '0;
        step(); step();
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h3000); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", ras_empty); end
        checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", ras_full); end
        checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL rst_miss got=%b exp=0", ras_miss); end
        checks++; if (ras_top !== 32'h0) begin errors++; $display("FAIL rst_top got=%h exp=0", ras_top); end
        rst = 1'b0;
    endtask

    task automatic test_branch();
        npc_op = 3'd1; brcmp_op = 3'd0; id_pc = 32'h3010;
        imm26 = 26'h000FFFF; rs = 32'd5; rt = 32'd5;
        #1;
        checks++; if (comp !== 1'b1) begin errors++; $display("FAIL beq_comp got=%b exp=1", comp); end
        checks++; if (npc !== 32'h300C) begin errors++; $display("FAIL beq_npc got=%h exp=%h", npc, 32'h300C); end
        checks++; if (laddr !== 32'h3018) begin errors++; $display("FAIL laddr got=%h exp=%h", laddr, 32'h3018); end
        step();
        checks++; if (pc !== 32'h300C) begin errors++; $display("FAIL beq_pc got=%h exp=%h", pc, 32'h300C); end
        brcmp_op = 3'd1;
        #1;
        checks++; if (comp !== 1'b0) begin errors++; $display("FAIL bne_comp got=%b exp=0", comp); end
        step();
        checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL bne_pc got=%h exp=%h", pc, 32'h3010); end
    endtask

    task automatic test_signed();
        npc_op = 3'd1; id_pc = 32'h3100;
        brcmp_op = 3'd4; rs = 32'h8000_0000; imm26 = 26'h4;
        step();
        checks++; if (pc !== 32'h3110) begin errors++; $display("FAIL bltz_pc got=%h exp=%h", pc, 32'h3110); end
        brcmp_op = 3'd5; rs = 32'h0; imm26 = 26'h8;
        step();
        checks++; if (pc !== 32'h3120) begin errors++; $display("FAIL bgez_pc got=%h exp=%h", pc, 32'h3120); end
        brcmp_op = 3'd3;
        #1;
        checks++; if (comp !== 1'b0) begin errors++; $display("FAIL bgtz_comp got=%b exp=0", comp); end
        step();
        checks++; if (pc !== 32'h3124) begin errors++; $display("FAIL bgtz_pc got=%h exp=%h", pc, 32'h3124); end
        brcmp_op = 3'd2;
        #1;
        checks++; if (comp !== 1'b1) begin errors++; $display("FAIL blez_comp got=%b exp=1", comp); end
        brcmp_op = 3'd6; rs = 32'd3; rt = 32'd3;
        #1;
        checks++; if (comp !== 1'b0) begin errors++; $display("FAIL unk_cmp got=%b exp=0", comp); end
        npc_op = 3'd0;
    endtask

    task automatic test_jump_link();
        npc_op = 3'd4; id_pc = 32'h3004; imm26 = 26'h0000C10;
        #1;
        checks++; if (npc !== 32'h3040) begin errors++; $display("FAIL jal_npc got=%h exp=%h", npc, 32'h3040); end
        checks++; if (laddr !== 32'h300C) begin errors++; $display("FAIL jal_laddr got=%h exp=%h", laddr, 32'h300C); end
        step();
        checks++; if (pc !== 32'h3040) begin errors++; $display("FAIL jal_pc got=%h exp=%h", pc, 32'h3040); end
        checks++; if (ras_top !== 32'h300C) begin errors++; $display("FAIL jal_top got=%h exp=%h", ras_top, 32'h300C); end
        checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL jal_empty got=%b exp=0", ras_empty); end
        npc_op = 3'd5; rs = 32'h300C;
        step();
        checks++; if (pc !== 32'h300C) begin errors++; $display("FAIL ret_pc got=%h exp=%h", pc, 32'h300C); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
        checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL ret_miss got=%b exp=0", ras_miss); end
        npc_op = 3'd3; rs = 32'h7003;
        #1;
        checks++; if (npc !== 32'h7000) begin errors++; $display("FAIL jr_npc got=%h exp=%h", npc, 32'h7000); end
        npc_op = 3'd2; id_pc = 32'hA000_0000; imm26 = 26'h3FF_FFFF;
        #1;
        checks++; if (npc !== 32'hAFFF_FFFC) begin errors++; $display("FAIL j_npc got=%h exp=%h", npc, 32'hAFFF_FFFC); end
        npc_op = 3'd0;
    endtask

    task automatic test_ras_bounds();
        logic [31:0] exp_top;
        npc_op = 3'd4; imm26 = 26'h1000;
        for (int i = 0; i < 5; i++) begin
            id_pc = 32'h4000 + 32'(i) * 32'h10;
            step();
            exp_top = 32'h4008 + 32'(i) * 32'h10;
            checks++; if (ras_top !== exp_top) begin errors++; $display("FAIL push%0d_top got=%h exp=%h", i, ras_top, exp_top); end
            checks++; if (ras_full !== (i >= 3)) begin errors++; $display("FAIL push%0d_full got=%b exp=%b", i, ras_full, (i >= 3)); end
        end
        checks++; if (pc !== 32'h4000) begin errors++; $display("FAIL push_pc got=%h exp=%h", pc, 32'h4000); end
        npc_op = 3'd5;
        for (int i = 0; i < 4; i++) begin
            rs = 32'h4048 - 32'(i) * 32'h10;
            step();
            checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL pop%0d_miss got=%b exp=0", i, ras_miss); end
            checks++; if (pc !== rs) begin errors++; $display("FAIL pop%0d_pc got=%h exp=%h", i, pc, rs); end
        end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL pop4_empty got=%b exp=1", ras_empty); end
        rs = 32'h4008;
        step();
        checks++; if (ras_miss !== 1'b1) begin errors++; $display("FAIL under_miss got=%b exp=1", ras_miss); end
        checks++; if (pc !== 32'h4008) begin errors++; $display("FAIL under_pc got=%h exp=%h", pc, 32'h4008); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL under_empty got=%b exp=1", ras_empty); end
        npc_op = 3'd0;
        step();
        checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL under_pulse got=%b exp=0", ras_miss); end
        npc_op = 3'd4; id_pc = 32'h5000; imm26 = 26'h1400;
        step();
        npc_op = 3'd5; rs = 32'h5010;
        step();
        checks++; if (ras_miss !== 1'b1) begin errors++; $display("FAIL mism_miss got=%b exp=1", ras_miss); end
        checks++; if (pc !== 32'h5010) begin errors++; $display("FAIL mism_pc got=%h exp=%h", pc, 32'h5010); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL mism_empty got=%b exp=1", ras_empty); end
        npc_op = 3'd0;
        step();
        checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL mism_pulse got=%b exp=0", ras_miss); end
    endtask

    task automatic test_stall();
        stall = 1'b1; npc_op = 3'd4; id_pc = 32'h6000; imm26 = 26'h1800;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 32'h5014) begin errors++; $display("FAIL stall%0d_pc got=%h exp=%h", i, pc, 32'h5014); end
            checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL stall%0d_empty got=%b exp=1", i, ras_empty); end
            checks++; if (npc !== 32'h6000) begin errors++; $display("FAIL stall%0d_npc got=%h exp=%h", i, npc, 32'h6000); end
        end
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'h6000) begin errors++; $display("FAIL rel_pc got=%h exp=%h", pc, 32'h6000); end
        checks++; if (ras_top !== 32'h6008) begin errors++; $display("FAIL rel_top got=%h exp=%h", ras_top, 32'h6008); end
        npc_op = 3'd5; rs = 32'h6008;
        step();
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL rel_single got=%b exp=1", ras_empty); end
        checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL rel_miss got=%b exp=0", ras_miss); end
        npc_op = 3'd7;
        step();
        checks++; if (pc !== 32'h600C) begin errors++; $display("FAIL undef_pc got=%h exp=%h", pc, 32'h600C); end
    endtask

    task automatic test_mid_reset();
        npc_op = 3'd4; id_pc = 32'h6100; imm26 = 26'h1800;
        step();
        stall = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL mrst_pc got=%h exp=%h", pc, 32'h3000); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got=%b exp=1", ras_empty); end
        checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL mrst_miss got=%b exp=0", ras_miss); end
        rst = 1'b0; stall = 1'b0; npc_op = 3'd0;
        step();
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL mrst_next got=%h exp=%h", pc, 32'h3004); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_signed();
        test_jump_link();
        test_ras_bounds();
        test_stall();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
